// File: rtl/dmem_axi_bridge.sv
// dmem_axi_bridge: turns one memory-stage load/store into one single-beat AXI transaction.
// Latency: minimum 3 stall cycles for a read or a write; mem_rdata is valid in DONE.
// Backpressure: every valid is held until its handshake; DONE waits for pipe_advance.
module dmem_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byteenable,
  input  logic        pipe_advance,
  output logic [31:0] mem_rdata,
  output logic        stall_req,
  output logic        bus_err,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        req;
  logic [1:0]  req_off;
  logic [2:0]  req_size;
  logic        aw_now, w_now;

  // The address carries the byte offset so the slave sees a naturally aligned
  // narrow access; the word-aligned low bits of mem_addr are never used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  // ID tie-off for the AR/AW channels; the id wires are not part of this port list.
  logic [3:0] axi_id_unused;
  assign axi_id_unused = AXI_ID;

  assign req = (mem_read | mem_write) && (mem_byteenable != 4'b0000);

  // Decode byte-lane offset (lowest active lane) and AXI size (lane count).
  always_comb begin
    req_off  = 2'd0;
    req_size = 3'd2;
    casez (mem_byteenable)
      4'b???1: req_off = 2'd0;
      4'b??10: req_off = 2'd1;
      4'b?100: req_off = 2'd2;
      4'b1000: req_off = 2'd3;
      default: req_off = 2'd0;
    endcase
    case (mem_byteenable)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 3'd0;
      4'b0011, 4'b1100:                   req_size = 3'd1;
      default:                            req_size = 3'd2;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      size_q    <= 3'd0;
      wdata_q   <= 32'd0;
      strb_q    <= 4'd0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic: latch the request once, then walk the AXI handshakes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    bus_err_d = bus_err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    // A channel counts as done if it completed earlier or handshakes this cycle.
    aw_now    = aw_done_q | awready;
    w_now     = w_done_q | wready;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d    = {mem_addr[31:2], req_off};
          size_d    = req_size;
          wdata_d   = mem_wdata;
          strb_d    = mem_byteenable;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          // A store wins when both strobes are raised together.
          state_d   = mem_write ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_d   = rdata;
          bus_err_d = (rresp != 2'b00);
          state_d   = DONE;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bus_err_d = (bresp != 2'b00);
          state_d   = DONE;
        end
      end
      DONE: begin
        // Stay here while another stall source freezes the stage; never re-issue.
        if (pipe_advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign arvalid   = (state_q == RD_ADDR);
  assign rready    = (state_q == RD_DATA);
  assign awvalid   = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid    = (state_q == WR_REQ) && !w_done_q;
  assign bready    = (state_q == WR_RESP);

  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign arsize    = size_q;
  assign awsize    = size_q;
  assign wdata     = wdata_q;
  assign wstrb     = strb_q;
  assign mem_rdata = rdata_q;
  assign bus_err   = bus_err_q;

  assign stall_req = ((state_q == IDLE) && req) ||
                     (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                     (state_q == WR_REQ)  || (state_q == WR_RESP);

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Bench for dmem_axi_bridge: drives memory-stage requests, models an AXI slave
// with programmable ready/valid delays, and checks each transaction against
// expectations queued when the request is issued.
module tb_dmem_axi_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteenable;
  logic        pipe_advance;
  logic [31:0] mem_rdata;
  logic        stall_req;
  logic        bus_err;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  dmem_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byteenable(mem_byteenable),
    .pipe_advance(pipe_advance), .mem_rdata(mem_rdata),
    .stall_req(stall_req), .bus_err(bus_err),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic [31:0] last_rdata;

  // Slave observations of the transaction just run.
  logic [31:0] obs_araddr, obs_awaddr, obs_wdata;
  logic [2:0]  obs_arsize, obs_awsize;
  logic [3:0]  obs_wstrb;
  int          ar_cnt, aw_cnt, w_cnt, stalls, aw_hs_cyc, w_hs_cyc;
  logic        ar_unstable, ar_drop, aw_drop, w_drop, w_rehigh, aw_held, timeout;

  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [3:0] be);
    logic [1:0] off;
    off = 2'd0;
    for (int i = 3; i >= 0; i--) if (be[i]) off = 2'(i);
    return {a[31:2], off};
  endfunction

  function automatic logic [2:0] model_size(input logic [3:0] be);
    case ($countones(be))
      1:       return 3'd0;
      2:       return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] rd, input logic err);
    exp_t n;
    mem_read = !wr;
    mem_write = wr;
    mem_addr = a;
    mem_byteenable = be;
    mem_wdata = wd;
    n.addr = model_addr(a, be);
    n.size = model_size(be);
    n.wr = wr;
    n.wdata = wd;
    n.strb = be;
    n.rdata = rd;
    n.err = err;
    exp_q.push_back(n);
  endtask

  task automatic clear_req();
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byteenable = 4'b0000;
  endtask

  task automatic release_done();
    pipe_advance = 1'b1;
    clear_req();
    step();
    pipe_advance = 1'b0;
  endtask

  // AXI slave: each ready/valid is raised after the given number of cycles
  // with the master's valid/ready up; runs until stall_req drops.
  task automatic run_slave(input int ar_dly, input int r_dly, input int aw_dly,
                           input int w_dly, input int b_dly,
                           input logic [31:0] rd, input logic [1:0] resp);
    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    logic ar_pend, aw_pend, w_pend;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    ar_pend = 0; aw_pend = 0; w_pend = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; stalls = 0; aw_hs_cyc = -1; w_hs_cyc = -1;
    ar_unstable = 0; ar_drop = 0; aw_drop = 0; w_drop = 0; w_rehigh = 0; aw_held = 0;
    obs_araddr = '0; obs_awaddr = '0; obs_wdata = '0;
    obs_arsize = '0; obs_awsize = '0; obs_wstrb = '0;
    timeout = 1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (!stall_req) begin
        timeout = 0;
        break;
      end
      stalls++;
      if (w_cnt > 0 && wvalid) w_rehigh = 1;
      if (w_cnt > 0 && awvalid) aw_held = 1;
      arready = 0;
      if (arvalid) begin
        if (!ar_pend) begin obs_araddr = araddr; obs_arsize = arsize; end
        else if (araddr !== obs_araddr || arsize !== obs_arsize) ar_unstable = 1;
        if (ar_wait >= ar_dly) begin arready = 1; ar_cnt++; ar_pend = 0; end
        else ar_pend = 1;
        ar_wait++;
      end else if (ar_pend) ar_drop = 1;
      awready = 0;
      if (awvalid) begin
        if (!aw_pend) begin obs_awaddr = awaddr; obs_awsize = awsize; end
        if (aw_wait >= aw_dly) begin awready = 1; aw_cnt++; aw_pend = 0; aw_hs_cyc = c; end
        else aw_pend = 1;
        aw_wait++;
      end else if (aw_pend) aw_drop = 1;
      wready = 0;
      if (wvalid) begin
        if (!w_pend) begin obs_wdata = wdata; obs_wstrb = wstrb; end
        if (w_wait >= w_dly) begin wready = 1; w_cnt++; w_pend = 0; w_hs_cyc = c; end
        else w_pend = 1;
        w_wait++;
      end else if (w_pend) w_drop = 1;
      rvalid = 0;
      rdata = 32'hBAD0BAD0;
      rresp = 2'b00;
      if (rready) begin
        if (r_wait >= r_dly) begin rvalid = 1; rdata = rd; rresp = resp; end
        r_wait++;
      end
      bvalid = 0;
      bresp = 2'b00;
      if (bready) begin
        if (b_wait >= b_dly) begin bvalid = 1; bresp = resp; end
        b_wait++;
      end
      step();
    end
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({stall_req, arvalid, rready, awvalid, wvalid, bready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000", {stall_req, arvalid, rready, awvalid, wvalid, bready});
    end
    checks++;
    if (mem_rdata !== 32'd0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got rdata=%h err=%b exp rdata=0 err=0", mem_rdata, bus_err);
    end
    checks++;
    if (araddr !== 32'd0 || wstrb !== 4'd0 || wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs got addr=%h strb=%b wdata=%h exp zeros", araddr, wstrb, wdata);
    end
    step();
  endtask

  task automatic test_lw();
    issue(1'b0, 32'h0000_1000, 4'b1111, 32'd0, 32'hDEAD_BEEF, 1'b0);
    run_slave(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
    e = exp_q.pop_front();
    checks++;
    if (timeout) begin errors++; $display("FAIL lw_timeout got=stuck exp=done"); end
    checks++;
    if (obs_araddr !== e.addr || obs_arsize !== e.size) begin
      errors++;
      $display("FAIL lw_ar got=%h/%0d exp=%h/%0d", obs_araddr, obs_arsize, e.addr, e.size);
    end
    checks++;
    if (stalls !== 3) begin errors++; $display("FAIL lw_stalls got=%0d exp=3", stalls); end
    checks++;
    if (mem_rdata !== e.rdata || bus_err !== e.err) begin
      errors++;
      $display("FAIL lw_rdata got=%h/%b exp=%h/%b", mem_rdata, bus_err, e.rdata, e.err);
    end
    checks++;
    if (ar_cnt !== 1 || aw_cnt !== 0 || w_cnt !== 0) begin
      errors++;
      $display("FAIL lw_channels got ar=%0d aw=%0d w=%0d exp 1/0/0", ar_cnt, aw_cnt, w_cnt);
    end
    last_rdata = e.rdata;
    release_done();
  endtask

  task automatic test_sb();
    issue(1'b1, 32'h0000_2000, 4'b0100, 32'h00AB_0000, 32'd0, 1'b0);
    run_slave(0, 0, 2, 0, 0, 32'd0, 2'b00);
    e = exp_q.pop_front();
    checks++;
    if (timeout) begin errors++; $display("FAIL sb_timeout got=stuck exp=done"); end
    checks++;
    if (obs_awaddr !== e.addr || obs_awsize !== e.size) begin
      errors++;
      $display("FAIL sb_aw got=%h/%0d exp=%h/%0d", obs_awaddr, obs_awsize, e.addr, e.size);
    end
    checks++;
    if (obs_wstrb !== e.strb || obs_wdata !== e.wdata) begin
      errors++;
      $display("FAIL sb_w got=%b/%h exp=%b/%h", obs_wstrb, obs_wdata, e.strb, e.wdata);
    end
    checks++;
    if (aw_hs_cyc - w_hs_cyc !== 2 || w_rehigh !== 1'b0 || aw_held !== 1'b1 || aw_drop || w_drop) begin
      errors++;
      $display("FAIL sb_split got gap=%0d rehigh=%b held=%b drop=%b%b exp gap=2 rehigh=0 held=1 drop=00",
               aw_hs_cyc - w_hs_cyc, w_rehigh, aw_held, aw_drop, w_drop);
    end
    checks++;
    if (stalls !== 5 || ar_cnt !== 0) begin
      errors++;
      $display("FAIL sb_stalls got=%0d ar=%0d exp=5 ar=0", stalls, ar_cnt);
    end
    checks++;
    if (mem_rdata !== last_rdata || bus_err !== e.err) begin
      errors++;
      $display("FAIL sb_done got=%h/%b exp=%h/%b", mem_rdata, bus_err, last_rdata, e.err);
    end
    release_done();
  endtask

  task automatic test_lh_slow_ar();
    issue(1'b0, 32'h0000_3000, 4'b1100, 32'd0, 32'h1234_5678, 1'b0);
    run_slave(5, 0, 0, 0, 0, 32'h1234_5678, 2'b00);
    e = exp_q.pop_front();
    checks++;
    if (obs_araddr !== e.addr || obs_arsize !== e.size) begin
      errors++;
      $display("FAIL lh_ar got=%h/%0d exp=%h/%0d", obs_araddr, obs_arsize, e.addr, e.size);
    end
    checks++;
    if (ar_unstable || ar_drop || stalls !== 8) begin
      errors++;
      $display("FAIL lh_hold got unstable=%b drop=%b stalls=%0d exp 0/0/8", ar_unstable, ar_drop, stalls);
    end
    checks++;
    if (mem_rdata !== e.rdata) begin
      errors++;
      $display("FAIL lh_rdata got=%h exp=%h", mem_rdata, e.rdata);
    end
    last_rdata = e.rdata;
    release_done();
  endtask

  task automatic test_bus_err();
    issue(1'b0, 32'h0000_4000, 4'b0010, 32'd0, 32'hCAFE_F00D, 1'b1);
    run_slave(0, 2, 0, 0, 0, 32'hCAFE_F00D, 2'b10);
    e = exp_q.pop_front();
    checks++;
    if (bus_err !== e.err || mem_rdata !== e.rdata || stalls !== 5) begin
      errors++;
      $display("FAIL rd_err got=%b/%h/%0d exp=%b/%h/5", bus_err, mem_rdata, stalls, e.err, e.rdata);
    end
    checks++;
    if (obs_araddr !== e.addr || obs_arsize !== e.size) begin
      errors++;
      $display("FAIL rd_err_ar got=%h/%0d exp=%h/%0d", obs_araddr, obs_arsize, e.addr, e.size);
    end
    last_rdata = e.rdata;
    release_done();
    issue(1'b1, 32'h0000_5000, 4'b0011, 32'h0000_BEEF, 32'd0, 1'b0);
    run_slave(0, 0, 0, 1, 1, 32'd0, 2'b00);
    e = exp_q.pop_front();
    checks++;
    if (bus_err !== e.err || mem_rdata !== last_rdata || stalls !== 5) begin
      errors++;
      $display("FAIL wr_clear got=%b/%h/%0d exp=%b/%h/5", bus_err, mem_rdata, stalls, e.err, last_rdata);
    end
    checks++;
    if (obs_awaddr !== e.addr || obs_awsize !== e.size || obs_wstrb !== e.strb || obs_wdata !== e.wdata) begin
      errors++;
      $display("FAIL wr_clear_aw got=%h/%0d/%b/%h exp=%h/%0d/%b/%h", obs_awaddr, obs_awsize,
               obs_wstrb, obs_wdata, e.addr, e.size, e.strb, e.wdata);
    end
    release_done();
  endtask

  task automatic test_done_hold();
    issue(1'b0, 32'h0000_6000, 4'b1111, 32'd0, 32'h600D_600D, 1'b0);
    run_slave(0, 0, 0, 0, 0, 32'h600D_600D, 2'b00);
    e = exp_q.pop_front();
    checks++;
    if (mem_rdata !== e.rdata || stalls !== 3) begin
      errors++;
      $display("FAIL hold_rd got=%h/%0d exp=%h/3", mem_rdata, stalls, e.rdata);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2;
      checks++;
      if (arvalid !== 1'b0 || stall_req !== 1'b0 || mem_rdata !== e.rdata) begin
        errors++;
        $display("FAIL hold_cyc%0d got arv=%b stall=%b rdata=%h exp 0/0/%h", k, arvalid, stall_req, mem_rdata, e.rdata);
      end
    end
    last_rdata = e.rdata;
    release_done();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 32'h0000_7000, 4'b1000, 32'h5A00_0000, 32'd0, 1'b0);
    run_slave(0, 0, 0, 0, 0, 32'd0, 2'b00);
    e = exp_q.pop_front();
    checks++;
    if (timeout || stalls !== 3 || obs_awaddr !== e.addr || obs_awsize !== e.size || obs_wstrb !== e.strb) begin
      errors++;
      $display("FAIL b2b_wr got to=%b stalls=%0d aw=%h/%0d strb=%b exp 0/3/%h/%0d/%b", timeout, stalls,
               obs_awaddr, obs_awsize, obs_wstrb, e.addr, e.size, e.strb);
    end
    release_done();
    issue(1'b0, 32'h0000_8000, 4'b0011, 32'd0, 32'h0BAD_CAFE, 1'b0);
    run_slave(0, 0, 0, 0, 0, 32'h0BAD_CAFE, 2'b00);
    e = exp_q.pop_front();
    checks++;
    if (timeout || stalls !== 3 || obs_araddr !== e.addr || obs_arsize !== e.size || mem_rdata !== e.rdata) begin
      errors++;
      $display("FAIL b2b_rd got to=%b stalls=%0d ar=%h/%0d rdata=%h exp 0/3/%h/%0d/%h", timeout, stalls,
               obs_araddr, obs_arsize, mem_rdata, e.addr, e.size, e.rdata);
    end
    last_rdata = e.rdata;
    release_done();
  endtask

  task automatic test_zero_be();
    mem_read = 1'b1;
    mem_write = 1'b1;
    mem_addr = 32'h0000_A000;
    mem_byteenable = 4'b0000;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin errors++; $display("FAIL zbe_stall got=%b exp=0", stall_req); end
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      checks++;
      if ({stall_req, arvalid, awvalid, wvalid} !== 4'b0000) begin
        errors++;
        $display("FAIL zbe_cyc%0d got=%b exp=0000", k, {stall_req, arvalid, awvalid, wvalid});
      end
    end
    clear_req();
    step();
  endtask

  task automatic test_rst_mid();
    issue(1'b0, 32'h0000_9000, 4'b1111, 32'd0, 32'h9999_9999, 1'b0);
    e = exp_q.pop_front();
    arready = 1'b1;
    step();
    #1;
    checks++;
    if (arvalid !== 1'b1 || araddr !== e.addr) begin
      errors++;
      $display("FAIL rstmid_ar got=%b/%h exp=1/%h", arvalid, araddr, e.addr);
    end
    step();
    arready = 1'b0;
    #1;
    checks++;
    if (rready !== 1'b1 || mem_rdata !== last_rdata) begin
      errors++;
      $display("FAIL rstmid_rdata_phase got=%b/%h exp=1/%h", rready, mem_rdata, last_rdata);
    end
    rst = 1'b1;
    clear_req();
    step();
    #1;
    checks++;
    if ({rready, arvalid, stall_req, bus_err} !== 4'b0000 || mem_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_after got=%b rdata=%h exp=0000 rdata=0", {rready, arvalid, stall_req, bus_err}, mem_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    mem_addr = '0; mem_read = 0; mem_write = 0; mem_wdata = '0; mem_byteenable = '0;
    pipe_advance = 0;
    arready = 0; rdata = '0; rresp = '0; rvalid = 0;
    awready = 0; wready = 0; bresp = '0; bvalid = 0;
    last_rdata = '0;
    test_reset();
    test_lw();
    test_sb();
    test_lh_slow_ar();
    test_bus_err();
    test_done_hold();
    test_back_to_back();
    test_zero_be();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
